sdram_host_port: RTL and testbench

//  Upstream front-end for sdram_controller. Buffers host requests (valid/ready) in a command FIFO,

---
 rtl/sdram_host_port.sv | 172 +++++++++++++++++
 tb/tb_sdram_host_port.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_port.sv
// Host-side front-end for sdram_controller: command FIFO, single-op issue FSM, one-entry read response.
// Optional watchdog enabled by defining SDRAM_PORT_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | waiting for a FIFO head that may issue (reads wait for a free response slot)
// S_ISSUE | enable held with address/data until the controller raises busy
// S_WAIT  | enable dropped; write waits for busy low, read waits for rd_ready
module sdram_host_port #(
   parameter int ADDR_WIDTH     = 24,
   parameter int FIFO_AW        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [15:0]           req_wdata,
   input  logic [1:0]            req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [15:0]           rsp_data,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [15:0]           wr_data,
   output logic                  wr_enable,
   output logic                  wr_mask_low,
   output logic                  wr_mask_high,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_enable,
   input  logic [15:0]           rd_data,
   input  logic                  rd_ready,
   input  logic                  busy,
   output logic                  err
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = ADDR_WIDTH + 19;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [EW-1:0]         fifo_mem [DEPTH];
   logic [FIFO_AW:0]      wr_ptr;
   logic [FIFO_AW:0]      rd_ptr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  head_we;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [15:0]           head_wdata;
   logic [1:0]            head_be;
   logic [1:0]            state;
   logic                  op_we;
   logic                  tmo;

   assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign req_ready  = !fifo_full;
   assign push       = req_valid && !fifo_full;
   assign {head_we, head_addr, head_wdata, head_be} = fifo_mem[rd_ptr[FIFO_AW-1:0]];
   // a read may only leave the FIFO when its response has somewhere to land
   assign pop        = (state == S_IDLE) && !fifo_empty && (head_we || !rsp_valid);

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {req_we, req_addr, req_wdata, req_be};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

`ifdef SDRAM_PORT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt;
   logic          progress;

   assign progress = ((state == S_ISSUE) && busy) ||
                     ((state == S_WAIT) && (op_we ? !busy : rd_ready));
   assign tmo      = (state != S_IDLE) && (tmo_cnt == '0) && !progress;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (pop)
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
         else if ((state != S_IDLE) && (tmo_cnt != '0))
            tmo_cnt <= tmo_cnt - 1'b1;
         if (tmo)
            err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         op_we        <= 1'b0;
         wr_addr      <= '0;
         rd_addr      <= '0;
         wr_data      <= '0;
         wr_enable    <= 1'b0;
         rd_enable    <= 1'b0;
         wr_mask_low  <= 1'b0;
         wr_mask_high <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
      end else begin
         if (rsp_valid && rsp_ready)
            rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  op_we        <= head_we;
                  wr_addr      <= head_addr;
                  rd_addr      <= head_addr;
                  wr_data      <= head_wdata;
                  wr_enable    <= head_we;
                  rd_enable    <= !head_we;
                  wr_mask_low  <= head_we && !head_be[0];
                  wr_mask_high <= head_we && !head_be[1];
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (busy) begin
                  wr_enable <= 1'b0;
                  rd_enable <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (op_we ? !busy : rd_ready) begin
                  if (!op_we) begin
                     rsp_data  <= rd_data;
                     rsp_valid <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         // watchdog abort only fires when the current state made no progress
         if (tmo) begin
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            state     <= S_IDLE;
            if (!op_we) begin
               rsp_data  <= 16'hDEAD;
               rsp_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_host_port.sv
// Bench for sdram_host_port: behavioural controller model plus read-data scoreboard.
module tb_sdram_host_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [23:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic [23:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_enable;
   logic        wr_mask_low;
   logic        wr_mask_high;
   logic [23:0] rd_addr;
   logic        rd_enable;
   logic [15:0] rd_data = '0;
   logic        rd_ready = 1'b0;
   logic        busy = 1'b0;
   logic        err;

   always #5 clk = ~clk;

   sdram_host_port #(.ADDR_WIDTH(24), .FIFO_AW(2), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
      .wr_mask_low(wr_mask_low), .wr_mask_high(wr_mask_high),
      .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
      .rd_ready(rd_ready), .busy(busy), .err(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // controller model: optional refresh delay before busy, busy for 2 cycles, rd_ready pulse at end
   logic [15:0] mem [256];
   logic [15:0] ref_mem [256];
   int          n_rd = 0;
   int          n_wr = 0;
   int          hold_err = 0;
   int          refresh_cycles = 0;
   bit          ctl_stall = 1'b0;
   int          m_st = 0;
   int          m_cnt = 0;
   logic        m_we = 1'b0;
   logic        m_ml = 1'b0;
   logic        m_mh = 1'b0;
   logic [23:0] m_addr = '0;
   logic [15:0] m_data = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         rd_ready <= 1'b0;
         m_st     <= 0;
         m_cnt    <= 0;
      end else begin
         rd_ready <= 1'b0;
         case (m_st)
            0: if (!ctl_stall && (rd_enable || wr_enable)) begin
                  m_we   <= wr_enable;
                  m_addr <= wr_enable ? wr_addr : rd_addr;
                  m_data <= wr_data;
                  m_ml   <= wr_mask_low;
                  m_mh   <= wr_mask_high;
                  if (refresh_cycles > 0) begin
                     m_cnt <= refresh_cycles;
                     m_st  <= 1;
                  end else begin
                     busy  <= 1'b1;
                     m_cnt <= 2;
                     m_st  <= 2;
                  end
               end
            1: begin
                  if (m_we ? (!wr_enable || wr_addr != m_addr || wr_data != m_data)
                           : (!rd_enable || rd_addr != m_addr))
                     hold_err <= hold_err + 1;
                  if (m_cnt == 1) begin
                     busy  <= 1'b1;
                     m_cnt <= 2;
                     m_st  <= 2;
                  end else begin
                     m_cnt <= m_cnt - 1;
                  end
               end
            default: begin
                  if (m_cnt == 1) begin
                     busy <= 1'b0;
                     m_st <= 0;
                     if (m_we) begin
                        if (!m_ml) mem[m_addr[7:0]][7:0]  <= m_data[7:0];
                        if (!m_mh) mem[m_addr[7:0]][15:8] <= m_data[15:8];
                        n_wr <= n_wr + 1;
                     end else begin
                        rd_data  <= mem[m_addr[7:0]];
                        rd_ready <= 1'b1;
                        n_rd     <= n_rd + 1;
                     end
                  end else begin
                     m_cnt <= m_cnt - 1;
                  end
               end
         endcase
      end
   end

   logic [15:0] sb [$];
   int          n_rd_exp = 0;
   int          n_wr_exp = 0;

   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
         else                check_val("rsp_data", {16'h0, rsp_data}, {16'h0, sb.pop_front()});
      end
   end

   task automatic push_req(input logic we, input logic [23:0] addr, input logic [15:0] data,
                           input logic [1:0] be, input bit expect_dead = 1'b0);
      int i;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      req_be    = be;
      for (i = 0; i < 2000 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         check_val("push_accept", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (we) begin
         if (be[0]) ref_mem[addr[7:0]][7:0]  = data[7:0];
         if (be[1]) ref_mem[addr[7:0]][15:8] = data[15:8];
         n_wr_exp++;
      end else begin
         sb.push_back(expect_dead ? 16'hDEAD : ref_mem[addr[7:0]]);
         if (!expect_dead) n_rd_exp++;
      end
   endtask

   task automatic wait_drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && (n_rd == n_rd_exp) && (n_wr == n_wr_exp) &&
                !busy && (m_st == 0) && !rd_enable && !wr_enable;
      end
      check_val(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic set_rsp_ready(input logic v);
      @(posedge clk);
      #1 rsp_ready = v;
   endtask

   task automatic wait_for(input string tag, input bit use_wr);
      int i;
      for (i = 0; i < 200 && !(use_wr ? wr_enable : rd_enable); i++) @(negedge clk);
      check_val(tag, {31'd0, use_wr ? wr_enable : rd_enable}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int en_cnt;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("rst_wr_enable", {31'd0, wr_enable}, 32'd0);
      check_val("rst_rd_enable", {31'd0, rd_enable}, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      // write then read back the same word, write held through a short refresh
      refresh_cycles = 3;
      push_req(1'b1, 24'h000123, 16'hBEEF, 2'b11);
      wait_for("t1_wr_en", 1'b1);
      check_val("t1_wr_addr", {8'h0, wr_addr}, 32'h000123);
      check_val("t1_wr_data", {16'h0, wr_data}, 32'hBEEF);
      check_val("t1_wr_masks", {30'd0, wr_mask_high, wr_mask_low}, 32'd0);
      push_req(1'b0, 24'h000123, 16'h0000, 2'b00);
      wait_for("t1_rd_en", 1'b0);
      check_val("t1_rd_addr", {8'h0, rd_addr}, 32'h000123);
      check_val("t1_rd_masks", {30'd0, wr_mask_high, wr_mask_low}, 32'd0);
      wait_drain("t1_drain");
      refresh_cycles = 0;

      // FIFO fill with one op stuck in issue: four accepted, fifth waits for a pop
      ctl_stall = 1'b1;
      push_req(1'b1, 24'h000010, 16'hA000, 2'b11);
      repeat (3) @(negedge clk);
      for (int k = 1; k <= 4; k++)
         push_req(1'b1, 24'h000010 + 24'(k), 16'hA000 + 16'(k), 2'b11);
      @(negedge clk);
      check_val("t2_full_ready", {31'd0, req_ready}, 32'd0);
      repeat (5) @(negedge clk);
      check_val("t2_full_hold", {31'd0, req_ready}, 32'd0);
      check_val("t2_no_progress", n_wr - n_wr_exp + 5, 32'd0);
      ctl_stall = 1'b0;
      push_req(1'b1, 24'h000015, 16'hA005, 2'b11);
      wait_drain("t2_drain");

      // long refresh before busy: read held stable, executed exactly once
      refresh_cycles = 12;
      base = n_rd;
      push_req(1'b0, 24'h000011, 16'h0000, 2'b00);
      wait_drain("t3_drain");
      check_val("t3_read_count", n_rd - base, 32'd1);
      check_val("t3_hold_stable", hold_err, 32'd0);
      refresh_cycles = 0;

      // two reads with response slot occupied: second must not issue
      set_rsp_ready(1'b0);
      base = n_rd;
      push_req(1'b0, 24'h000012, 16'h0000, 2'b00);
      push_req(1'b0, 24'h000013, 16'h0000, 2'b00);
      for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
      check_val("t4_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
      en_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd_enable) en_cnt++;
      end
      check_val("t4_rd_blocked", en_cnt, 32'd0);
      check_val("t4_one_read", n_rd - base, 32'd1);
      set_rsp_ready(1'b1);
      wait_drain("t4_drain");
      check_val("t4_two_reads", n_rd - base, 32'd2);

      // partial write over all-ones
      push_req(1'b1, 24'h000020, 16'hFFFF, 2'b11);
      wait_drain("t5_fill");
      push_req(1'b1, 24'h000020, 16'h1234, 2'b01);
      wait_for("t5_wr_en", 1'b1);
      check_val("t5_mask_high", {31'd0, wr_mask_high}, 32'd1);
      check_val("t5_mask_low", {31'd0, wr_mask_low}, 32'd0);
      push_req(1'b0, 24'h000020, 16'h0000, 2'b00);
      wait_drain("t5_drain");

      // reset while waiting on a read
      push_req(1'b0, 24'h000011, 16'h0000, 2'b00);
      begin
         int i;
         for (i = 0; i < 200 && !(busy && !rd_enable); i++) @(negedge clk);
      end
      check_val("t6_in_wait", {31'd0, busy && !rd_enable}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("t6_rd_enable", {31'd0, rd_enable}, 32'd0);
      check_val("t6_wr_enable", {31'd0, wr_enable}, 32'd0);
      check_val("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_val("t6_req_ready", {31'd0, req_ready}, 32'd1);
      sb.delete();
      n_rd_exp = n_rd;
      n_wr_exp = n_wr;
      @(negedge clk);
      rst_n = 1'b1;

`ifdef SDRAM_PORT_TIMEOUT_EN
      ctl_stall = 1'b1;
      push_req(1'b0, 24'h000011, 16'h0000, 2'b00, 1'b1);
      en_cnt = 0;
      for (int i = 0; i < 300 && !rsp_valid; i++) begin
         @(negedge clk);
         if (rd_enable) en_cnt++;
      end
      check_val("tmo_enable_cycles", en_cnt, 32'd64);
      check_val("tmo_err", {31'd0, err}, 32'd1);
      repeat (5) @(negedge clk);
      check_val("tmo_err_sticky", {31'd0, err}, 32'd1);
      check_val("tmo_no_reissue", {31'd0, rd_enable}, 32'd0);
      ctl_stall = 1'b0;
      wait_drain("tmo_drain");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("tmo_err_cleared", {31'd0, err}, 32'd0);
`else
      ctl_stall = 1'b1;
      push_req(1'b0, 24'h000011, 16'h0000, 2'b00);
      repeat (100) @(negedge clk);
      check_val("stall_rd_held", {31'd0, rd_enable}, 32'd1);
      check_val("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_val("stall_err", {31'd0, err}, 32'd0);
      ctl_stall = 1'b0;
      wait_drain("stall_drain");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
